// File: rtl/tv_pkg.sv
// Shared types and constants for the test-vector recorder.
// A record packs five 12-bit fields {a, b, c, d, y}, with a in the top bits.
package tv_pkg;

   localparam int VEC_W_DEFAULT = 60;

   // Bit offsets of each 12-bit field inside a record.
   localparam int A_LSB = 48;
   localparam int B_LSB = 36;
   localparam int C_LSB = 24;
   localparam int D_LSB = 12;
   localparam int Y_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DUMP
   } state_t;

endpackage

// File: rtl/tv_ram.sv
// Record buffer for the recorder.
// Single-clock simple dual-port RAM: one write port and one read port.
// The read data is registered, so it appears one cycle after re.
// rdata keeps its value on cycles where re is low, which lets the
// reader stall without re-reading.
module tv_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int VEC_W  = 60
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [VEC_W-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [VEC_W-1:0]  rdata
);

   logic [VEC_W-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port. There is no reset, so the buffer maps onto block RAM.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/tv_recorder.sv
// On-chip test-vector recorder.
// In CAPTURE it stores records in arrival order and counts records flagged
// as mismatches. In DUMP it streams the stored records out over valid/ready.
// The dump path has two stages: the RAM output register, then the output
// register. A read is issued only when the RAM stage is empty or is moving
// forward in the same cycle. This keeps a stalled word stable on out_data
// and still allows one word per cycle when the sink is always ready.
module tv_recorder
   import tv_pkg::*;
#(
   parameter int VEC_W  = VEC_W_DEFAULT,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int ERR_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              cap_valid,
   input  logic [VEC_W-1:0]  cap_data,
   input  logic              cap_mismatch,
   output logic              cap_ready,
   input  logic              dump_start,
   output logic              out_valid,
   output logic [VEC_W-1:0]  out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic [ERR_W-1:0]  err_count,
   output logic              full,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state_reg, state_next;
   logic [ADDR_W:0]  count_reg;
   logic [ADDR_W:0]  rd_ptr_reg;
   logic [ERR_W-1:0] err_count_reg;
   logic             rd_pend_reg;
   logic             out_valid_reg;
   logic             out_last_reg;
   logic [VEC_W-1:0] out_data_reg;
   logic             done_reg;
   logic [VEC_W-1:0] ram_rdata;

   logic in_dump;
   logic full_w;
   logic cap_accept;
   logic rd_move;
   logic rd_issue;
   logic last_xfer;

   assign in_dump    = (state_reg == DUMP);
   assign full_w     = (count_reg == CNT_FULL);
   // If arm arrives in the same cycle as a record, that record is discarded.
   assign cap_accept = (state_reg == CAPTURE) && cap_valid && !full_w && !arm;
   // Move the RAM word into the output register when that register is empty or is being emptied.
   assign rd_move    = in_dump && rd_pend_reg && (!out_valid_reg || out_ready);
   // Start the next read only when the RAM output stage is free to take new data.
   assign rd_issue   = in_dump && (rd_ptr_reg < count_reg) && (!rd_pend_reg || rd_move);
   assign last_xfer  = in_dump && out_valid_reg && out_ready && out_last_reg;

   tv_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .VEC_W  (VEC_W)
   ) u_ram (
      .clk   (clk),
      .we    (cap_accept),
      .waddr (count_reg[ADDR_W-1:0]),
      .wdata (cap_data),
      .re    (rd_issue),
      .raddr (rd_ptr_reg[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic. arm takes priority over dump_start. DUMP ignores both inputs.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (arm) begin
               state_next = CAPTURE;
            end else if (dump_start) begin
               state_next = DUMP;
            end
         end
         CAPTURE: begin
            if (!arm && dump_start) begin
               state_next = DUMP;
            end
         end
         DUMP: begin
            if ((count_reg == '0) || last_xfer) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Record and mismatch counters. arm clears them; an accepted record advances them.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg     <= '0;
         err_count_reg <= '0;
      end else if (arm && !in_dump) begin
         count_reg     <= '0;
         err_count_reg <= '0;
      end else if (cap_accept) begin
         count_reg <= count_reg + CNT_ONE;
         if (cap_mismatch && (err_count_reg != ERR_MAX)) begin
            err_count_reg <= err_count_reg + ERR_ONE;
         end
      end
   end

   // Dump pipeline: read pointer, RAM-stage occupancy flag, and the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg    <= '0;
         rd_pend_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_data_reg  <= '0;
      end else if (!in_dump) begin
         rd_ptr_reg    <= '0;
         rd_pend_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else begin
         if (rd_issue) begin
            rd_ptr_reg  <= rd_ptr_reg + CNT_ONE;
            rd_pend_reg <= 1'b1;
         end else if (rd_move) begin
            rd_pend_reg <= 1'b0;
         end
         if (rd_move) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ram_rdata;
            // The RAM stage holds index rd_ptr-1, so this word is the last one when rd_ptr == count.
            out_last_reg  <= (rd_ptr_reg == count_reg);
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
         end
      end
   end

   // done pulses for one cycle when a dump finishes.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_reg <= 1'b0;
      end else begin
         done_reg <= in_dump && (state_next == IDLE);
      end
   end

   assign cap_ready = (state_reg == CAPTURE) && !full_w;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign count     = count_reg;
   assign err_count = err_count_reg;
   assign full      = full_w;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;

endmodule

// File: tb/tb_tv_recorder.sv
// Self-checking bench for tv_recorder.
// A behavioural model keeps the recorder's mode, the stored records and the
// counters. Each cycle, on the falling edge, the DUT outputs are checked
// against the model. The model is then advanced with the inputs for the
// next rising edge.
`timescale 1ns/1ps
module tb_tv_recorder;
   import tv_pkg::*;

   localparam int VW    = 60;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int EW    = 16;

   logic          clk = 1'b0;
   logic          reset, arm, cap_valid, cap_mismatch, dump_start, out_ready;
   logic [VW-1:0] cap_data;
   logic          cap_ready, out_valid, out_last, full, busy, done;
   logic [VW-1:0] out_data;
   logic [AW:0]   count;
   logic [EW-1:0] err_count;

   always #5 clk = ~clk;

   tv_recorder #(.VEC_W(VW), .DEPTH(DEPTH), .ADDR_W(AW), .ERR_W(EW)) dut (
      .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid),
      .cap_data(cap_data), .cap_mismatch(cap_mismatch), .cap_ready(cap_ready),
      .dump_start(dump_start), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready), .count(count),
      .err_count(err_count), .full(full), .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model. m_mode: 0 = idle, 1 = capture, 2 = dump.
   int            m_mode, m_count, m_err, m_idx, dump_cyc;
   logic [VW-1:0] m_mem [DEPTH];
   bit            exp_done, prev_stall, prev_last;
   logic [VW-1:0] prev_data;
   logic [VW-1:0] got[$];
   int            last_pos[$];
   int            ndone;

   // Compare one value against its expected value and print a FAIL line on mismatch.
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Build a record from its five 12-bit fields.
   function automatic logic [VW-1:0] mk_rec(input logic [11:0] a, input logic [11:0] b,
                                            input logic [11:0] c, input logic [11:0] d,
                                            input logic [11:0] y);
      logic [VW-1:0] r;
      r = '0;
      r[A_LSB +: 12] = a;
      r[B_LSB +: 12] = b;
      r[C_LSB +: 12] = c;
      r[D_LSB +: 12] = d;
      r[Y_LSB +: 12] = y;
      return r;
   endfunction

   // Check the DUT outputs against the model. Called on the falling edge.
   task automatic check_cycle();
      chk("count", 64'(count), 64'(m_count));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("full", 64'(full), 64'(m_count == DEPTH));
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("cap_ready", 64'(cap_ready), 64'(m_mode == 1 && m_count < DEPTH));
      chk("done", 64'(done), 64'(exp_done));
      if (prev_stall) begin
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_data", 64'(out_data), 64'(prev_data));
         chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (m_mode == 2 && m_idx < m_count) begin
         if (out_valid) begin
            chk("out_data", 64'(out_data), 64'(m_mem[m_idx]));
            chk("out_last", 64'(out_last), 64'(m_idx == m_count - 1));
         end
         if (m_idx == 0 && dump_cyc == 2) chk("first_word_latency", 64'(out_valid), 64'(1));
      end else begin
         chk("out_valid_quiet", 64'(out_valid), 64'(0));
      end
      if (done) ndone++;
   endtask

   // Advance the model by the rising edge that follows, using the current inputs.
   task automatic update_model();
      bit hs;
      hs = out_valid && out_ready;
      if (hs) begin
         got.push_back(out_data);
         if (out_last) last_pos.push_back(got.size() - 1);
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      prev_last  = out_last;
      exp_done   = 1'b0;
      if (reset) begin
         m_mode = 0; m_count = 0; m_err = 0; m_idx = 0;
      end else begin
         case (m_mode)
            0: begin
               if (arm) begin
                  m_mode = 1; m_count = 0; m_err = 0;
               end else if (dump_start) begin
                  m_mode = 2; m_idx = 0; dump_cyc = 0;
               end
            end
            1: begin
               if (arm) begin
                  m_count = 0; m_err = 0;
               end else begin
                  if (cap_valid && m_count < DEPTH) begin
                     m_mem[m_count] = cap_data;
                     m_count++;
                     if (cap_mismatch && m_err < (2**EW) - 1) m_err++;
                  end
                  if (dump_start) begin
                     m_mode = 2; m_idx = 0; dump_cyc = 0;
                  end
               end
            end
            default: begin
               dump_cyc++;
               if (hs && m_idx < m_count) m_idx++;
               if (m_idx >= m_count) begin
                  m_mode = 0; exp_done = 1'b1;
               end
            end
         endcase
      end
   endtask

   // Run one clock cycle: check on the falling edge, then move inputs to just after the rising edge.
   task automatic step();
      @(negedge clk);
      check_cycle();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   // Feed n accepted records of random data with random gaps between them.
   task automatic capture(input int n, input int mis_pct);
      int k;
      k = 0;
      while (k < n) begin
         cap_valid    = ($urandom % 4 != 0);
         cap_data     = VW'({$urandom, $urandom});
         cap_mismatch = ($urandom % 100 < mis_pct);
         if (cap_valid) k++;
         step();
      end
      cap_valid = 1'b0;
      cap_mismatch = 1'b0;
   endtask

   // Start a dump and run it to completion.
   // rnd_ready = 1 toggles out_ready at random; cap_with_start also drives a record on the start cycle.
   task automatic run_dump(input bit rnd_ready, input bit cap_with_start);
      got.delete();
      last_pos.delete();
      ndone = 0;
      dump_start = 1'b1;
      out_ready  = 1'b1;
      cap_valid  = cap_with_start;
      cap_data   = VW'({$urandom, $urandom});
      step();
      dump_start = 1'b0;
      cap_valid  = 1'b0;
      for (int n = 0; m_mode == 2; n++) begin
         if (n > 4 * DEPTH + 50) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: got %0d words expected %0d", got.size(), m_count);
            do_reset();
            break;
         end
         out_ready  = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
         arm        = ($urandom % 8 == 0);
         dump_start = ($urandom % 8 == 0);
         step();
      end
      arm = 1'b0;
      dump_start = 1'b0;
      out_ready = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [VW-1:0] saved[$];

   initial begin
      reset = 1'b1; arm = 1'b0; cap_valid = 1'b0; cap_mismatch = 1'b0;
      cap_data = '0; dump_start = 1'b0; out_ready = 1'b1;
      m_mode = 0; m_count = 0; m_err = 0; m_idx = 0; dump_cyc = 0;
      exp_done = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; ndone = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_count", 64'(count), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      step();

      // Capture three known records with a mismatch on the second, then dump them.
      do_arm();
      for (int i = 1; i <= 3; i++) begin
         cap_valid    = 1'b1;
         cap_data     = mk_rec(12'(i), 12'h0b0, 12'h0c0, 12'h0d0, 12'(12'hfff - i));
         cap_mismatch = (i == 2);
         step();
      end
      cap_valid = 1'b0; cap_mismatch = 1'b0;
      chk("t1_count", 64'(count), 64'(3));
      chk("t1_err", 64'(err_count), 64'(1));
      run_dump(1'b0, 1'b0);
      chk("t1_words", 64'(got.size()), 64'(3));
      chk("t1_word0", 64'(got[0]), 64'(60'h0010b00c00d0ffe));
      chk("t1_word1", 64'(got[1]), 64'(60'h0020b00c00d0ffd));
      chk("t1_word2", 64'(got[2]), 64'(60'h0030b00c00d0ffc));
      chk("t1_last_count", 64'(last_pos.size()), 64'(1));
      chk("t1_last_pos", 64'(last_pos[0]), 64'(2));
      chk("t1_done_pulses", 64'(ndone), 64'(1));

      // Fill the buffer, then offer four more records, which must be dropped.
      do_arm();
      for (int i = 0; i < DEPTH + 4; i++) begin
         cap_valid    = 1'b1;
         cap_data     = mk_rec(12'(i), 12'(i * 3), 12'h5a5, 12'h000, 12'(~i));
         cap_mismatch = (i % 7 == 0);
         step();
      end
      cap_valid = 1'b0; cap_mismatch = 1'b0;
      chk("fill_full", 64'(full), 64'(1));
      chk("fill_cap_ready", 64'(cap_ready), 64'(0));
      chk("fill_count", 64'(count), 64'(256));
      run_dump(1'b0, 1'b0);
      chk("fill_words", 64'(got.size()), 64'(256));
      chk("fill_word255", 64'(got[255]), 64'(60'h0ff2fd5a5000f00));
      chk("fill_last_pos", 64'(last_pos[0]), 64'(255));

      // Dump with a randomly stalling sink, then dump again: both dumps must match.
      do_arm();
      capture(20, 30);
      run_dump(1'b1, 1'b0);
      saved = got;
      run_dump(1'b1, 1'b0);
      chk("repeat_size", 64'(got.size()), 64'(saved.size()));
      for (int i = 0; i < saved.size(); i++) chk("repeat_word", 64'(got[i]), 64'(saved[i]));
      chk("repeat_done", 64'(ndone), 64'(1));

      // arm and dump_start together while idle: arm wins. Then a record arrives with dump_start.
      arm = 1'b1; dump_start = 1'b1;
      step();
      arm = 1'b0; dump_start = 1'b0;
      chk("armwin_busy", 64'(busy), 64'(1));
      chk("armwin_count", 64'(count), 64'(0));
      capture(2, 50);
      run_dump(1'b1, 1'b1);
      chk("startcap_count", 64'(count), 64'(3));
      chk("startcap_words", 64'(got.size()), 64'(3));

      // Empty dump: no words, one done pulse, ends idle.
      do_reset();
      run_dump(1'b0, 1'b0);
      chk("empty_words", 64'(got.size()), 64'(0));
      chk("empty_done", 64'(ndone), 64'(1));
      chk("empty_busy", 64'(busy), 64'(0));

      // Reset while word 5 of a 10-word dump is in flight.
      do_arm();
      capture(10, 50);
      got.delete(); last_pos.delete();
      dump_start = 1'b1; out_ready = 1'b1;
      step();
      dump_start = 1'b0;
      for (int n = 0; m_idx < 4; n++) begin
         if (n > 100) begin
            checks++; errors++;
            $display("FAIL midreset_timeout: got %0d words expected 4", m_idx);
            break;
         end
         step();
      end
      do_reset();
      chk("midreset_out_valid", 64'(out_valid), 64'(0));
      chk("midreset_count", 64'(count), 64'(0));
      chk("midreset_err", 64'(err_count), 64'(0));
      chk("midreset_busy", 64'(busy), 64'(0));
      ndone = 0;
      step();
      chk("midreset_no_done", 64'(ndone), 64'(0));
      do_arm();
      capture(5, 20);
      run_dump(1'b1, 1'b0);
      chk("postreset_words", 64'(got.size()), 64'(5));

      // Random sessions. Some re-arm mid-capture with a record that must be discarded.
      for (int r = 0; r < 6; r++) begin
         do_arm();
         capture($urandom_range(1, 40), 25);
         if (r % 2 == 1) begin
            arm = 1'b1; cap_valid = 1'b1; cap_data = VW'({$urandom, $urandom});
            step();
            arm = 1'b0; cap_valid = 1'b0;
            chk("rearm_count", 64'(count), 64'(0));
            capture($urandom_range(1, 30), 40);
         end
         run_dump(1'b1, 1'b0);
         chk("session_words", 64'(got.size()), 64'(m_count));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
